// File: rtl/pulse_stretch.sv
// pulse_stretch: turns single-cycle request strobes into fixed-width output
// pulses with a guaranteed low gap between back-to-back pulses. Requests
// arriving while a pulse is in flight are held in a saturating pending count.
// A request dropped because the count is full sets a sticky ovf flag.
//
// Optional build macro: PULSE_STRETCH_RETRIG_EN
//   defined   - a strobe during HIGH reloads the high counter (retrigger)
//               instead of queuing. Strobes during GAP still queue.
//   undefined - every strobe that cannot start a pulse at once is queued.
//
// Request interface: 'in' is a plain strobe with no back-pressure. Every clk
// edge that samples in=1 is exactly one request. It is either started at
// once, queued, merged into the running pulse (retrigger build), or dropped
// with ovf set.
module pulse_stretch #(
  parameter int HIGH_CYC = 5,
  parameter int GAP_CYC  = 2,
  parameter int PEND_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in,
  input  logic              clr_ovf,
  output logic              out,
  output logic              busy,
  output logic [PEND_W-1:0] pend,
  output logic              ovf
);

  localparam int MAX_HG  = (HIGH_CYC > GAP_CYC) ? HIGH_CYC : GAP_CYC;
  localparam int MAX_CYC = (MAX_HG > 2) ? MAX_HG : 2;
  localparam int CW      = $clog2(MAX_CYC);

  localparam logic [CW-1:0] HIGH_LOAD = CW'(HIGH_CYC - 1);
  localparam logic [CW-1:0] GAP_LOAD  = (GAP_CYC > 0) ? CW'(GAP_CYC - 1) : '0;
  localparam bit            GAP_EN    = (GAP_CYC > 0);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  if (HIGH_CYC < 1) begin : g_bad_high_cyc
    $error("pulse_stretch: HIGH_CYC must be >= 1");
  end

  logic [1:0]        state, state_d;
  logic [CW-1:0]     cnt, cnt_d;
  logic [PEND_W-1:0] pend_d;
  logic              ovf_d;
  logic              take;      // a pulse starts on this edge
  logic              retrig;    // strobe absorbed by reloading the high counter
  logic              cnt_zero;
  logic              pend_any;
  logic              pend_full;

  assign cnt_zero  = (cnt == '0);
  assign pend_any  = (pend != '0);
  assign pend_full = &pend;

`ifdef PULSE_STRETCH_RETRIG_EN
  assign retrig = in && (state == ST_HIGH);
`else
  assign retrig = 1'b0;
`endif

  // Next state and cycle counter; 'take' marks a pulse start that consumes
  // either a queued request or the strobe arriving this cycle.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    take    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (in) begin
          state_d = ST_HIGH;
          cnt_d   = HIGH_LOAD;
          take    = 1'b1;
        end
      end
      ST_HIGH: begin
        if (retrig) begin
          cnt_d = HIGH_LOAD;
        end else if (!cnt_zero) begin
          cnt_d = cnt - 1'b1;
        end else if (GAP_EN) begin
          state_d = ST_GAP;
          cnt_d   = GAP_LOAD;
        end else if (pend_any || in) begin
          // No gap configured: chain straight into the next pulse.
          cnt_d = HIGH_LOAD;
          take  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (!cnt_zero) begin
          cnt_d = cnt - 1'b1;
        end else if (pend_any || in) begin
          state_d = ST_HIGH;
          cnt_d   = HIGH_LOAD;
          take    = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Pending-count bookkeeping. A start drains the queue before it looks at
  // the new strobe, so a strobe arriving with a start only bypasses the
  // queue when the queue is empty; otherwise the count stays level.
  always_comb begin
    pend_d = pend;
    ovf_d  = ovf;
    if (take) begin
      if (pend_any && !in) begin
        pend_d = pend - 1'b1;
      end
    end else if (in && !retrig) begin
      if (pend_full) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend + 1'b1;
      end
    end
    // A fresh overflow outranks a clear in the same cycle.
    if (clr_ovf && !(ovf_d && !ovf)) begin
      ovf_d = 1'b0;
    end
  end

  // State, counter, queue and registered outputs; reset drops everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      out   <= 1'b0;
      busy  <= 1'b0;
      pend  <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      out   <= (state_d == ST_HIGH);
      busy  <= (state_d != ST_IDLE);
      pend  <= pend_d;
      ovf   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_pulse_stretch.sv
// Bench for pulse_stretch: two instances (default GAP_CYC=2 and GAP_CYC=0)
// against a timeline model that tracks pulse start/end edge numbers and a
// plain pending count, plus directed literal expectations per scenario.
module tb_pulse_stretch;

  localparam int H    = 5;
  localparam int PMAX = 15;

  logic       clk, rst_n;
  logic       in0, in1, clr0, clr1;
  logic       out0, busy0, ovf0, out1, busy1, ovf1;
  logic [3:0] pend0, pend1;

  pulse_stretch #(.HIGH_CYC(5), .GAP_CYC(2), .PEND_W(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in(in0), .clr_ovf(clr0),
    .out(out0), .busy(busy0), .pend(pend0), .ovf(ovf0)
  );

  pulse_stretch #(.HIGH_CYC(5), .GAP_CYC(0), .PEND_W(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in(in1), .clr_ovf(clr1),
    .out(out1), .busy(busy1), .pend(pend1), .ovf(ovf1)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard counters ----------------
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- timeline model ----------------
  // A pulse occupies edges [m_s, m_e); a new one may start once the edge
  // number reaches m_e + gap. Outputs after edge n follow directly.
  int n_edge = 0;
  int m_s[2];
  int m_e[2];
  int m_pend[2];
  bit m_ovf[2];

  function automatic int gap_of(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_s[k]    = -1000;
      m_e[k]    = -1000;
      m_pend[k] = 0;
      m_ovf[k]  = 1'b0;
    end
  endtask

  task automatic model_step(input int k, input bit rq_in, input bit clr);
    bit rq;
    bit set_ovf;
`ifdef PULSE_STRETCH_RETRIG_EN
    bit hi_before;
`endif
    rq      = rq_in;
    set_ovf = 1'b0;
`ifdef PULSE_STRETCH_RETRIG_EN
    hi_before = (m_s[k] <= n_edge - 1) && (n_edge - 1 < m_e[k]);
    if (rq && hi_before) begin
      m_e[k] = n_edge + H;
      rq     = 1'b0;
    end
`endif
    if ((n_edge >= m_e[k] + gap_of(k)) && (m_pend[k] > 0 || rq)) begin
      m_s[k] = n_edge;
      m_e[k] = n_edge + H;
      if (m_pend[k] > 0) m_pend[k]--;
      else rq = 1'b0;
    end
    if (rq) begin
      if (m_pend[k] == PMAX) set_ovf = 1'b1;
      else m_pend[k]++;
    end
    if (set_ovf) m_ovf[k] = 1'b1;
    else if (clr) m_ovf[k] = 1'b0;
  endtask

  task automatic compare_inst(input int k, input bit o, input bit b, input int p, input bit v);
    bit eo, eb;
    if (!rst_n) begin
      eo = 1'b0;
      eb = 1'b0;
    end else begin
      eo = (m_s[k] <= n_edge) && (n_edge < m_e[k]);
      eb = (n_edge < m_e[k] + gap_of(k));
    end
    chk($sformatf("model_out%0d", k), int'(o), int'(eo));
    chk($sformatf("model_busy%0d", k), int'(b), int'(eb));
    chk($sformatf("model_pend%0d", k), p, m_pend[k]);
    chk($sformatf("model_ovf%0d", k), int'(v), int'(m_ovf[k]));
  endtask

  // Compare process: step the model with the inputs sampled at each edge,
  // then check both instances 1 time unit later.
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        model_reset();
      end else begin
        n_edge++;
        model_step(0, in0, clr0);
        model_step(1, in1, clr1);
      end
      compare_inst(0, out0, busy0, int'(pend0), ovf0);
      compare_inst(1, out1, busy1, int'(pend1), ovf1);
    end
  end

  // ---------------- driver and tallies ----------------
  int  hi0, bz0, rise0, maxp0, hi1, rise1;
  bit  prev0, prev1;

  task automatic clr_tally();
    hi0 = 0; bz0 = 0; rise0 = 0; maxp0 = 0; hi1 = 0; rise1 = 0;
    prev0 = out0; prev1 = out1;
  endtask

  // One clock cycle: apply inputs after the falling edge, observe after the
  // following rising edge.
  task automatic cyc(input bit a0, input bit a1, input bit c0);
    @(negedge clk);
    in0  = a0;
    in1  = a1;
    clr0 = c0;
    @(posedge clk);
    #2;
    if (out0 && !prev0) rise0++;
    if (out1 && !prev1) rise1++;
    prev0 = out0;
    prev1 = out1;
    if (out0) hi0++;
    if (busy0) bz0++;
    if (out1) hi1++;
    if (int'(pend0) > maxp0) maxp0 = int'(pend0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    rst_n = 1'b0;
    in0 = 1'b0; in1 = 1'b0; clr0 = 1'b0; clr1 = 1'b0;
    @(posedge clk);
    #2;
    chk("reset_out", int'(out0), 0);
    chk("reset_busy", int'(busy0), 0);
    chk("reset_pend", int'(pend0), 0);
    chk("reset_ovf", int'(ovf0), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Single strobe: 5 high cycles from the sampling edge, 7 busy cycles.
    clr_tally();
    cyc(1'b1, 1'b0, 1'b0);
    chk("single_out_first", int'(out0), 1);
    idle(11);
    chk("single_high_cycles", hi0, 5);
    chk("single_busy_cycles", bz0, 7);
    chk("single_pend_max", maxp0, 0);
    chk("single_rises", rise0, 1);

    // Two strobes two cycles apart: one queued, 5 high, 2 low, 5 high.
    clr_tally();
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("two_pend_after_2nd", int'(pend0), 1);
    idle(15);
    chk("two_high_cycles", hi0, 10);
    chk("two_rises", rise0, 2);
    chk("two_busy_cycles", bz0, 14);
    chk("two_end_out", int'(out0), 0);
    chk("two_end_busy", int'(busy0), 0);

    // Strobe held for 20 edges. Edges 0/7/14 start pulses (the ones at 7
    // and 14 keep the count level), so the count hits 15 at edge 17 and
    // edges 18-19 are dropped: 18 accepted requests, 18 pulses in total.
    clr_tally();
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 1'b0);
    chk("sat_pend", int'(pend0), 15);
    chk("sat_ovf", int'(ovf0), 1);
    cyc(1'b0, 1'b0, 1'b1);
    chk("sat_ovf_cleared", int'(ovf0), 0);
    chk("sat_pend_after_clr", int'(pend0), 15);
    idle(140);
    chk("sat_total_pulses", rise0, 18);
    chk("sat_drained_pend", int'(pend0), 0);
    chk("sat_drained_busy", int'(busy0), 0);

    // GAP_CYC=0 instance: three back-to-back strobes, one 15-cycle pulse.
    clr_tally();
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0);
    idle(18);
    chk("nogap_high_cycles", hi1, 15);
    chk("nogap_rises", rise1, 1);
    chk("nogap_end_out", int'(out1), 0);

    // Reset on the 3rd high cycle with two requests queued.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0);
    chk("rst_pre_pend", int'(pend0), 2);
    chk("rst_pre_out", int'(out0), 1);
    #1;
    rst_n = 1'b0;
    in0   = 1'b0;
    #1;
    chk("rst_mid_out", int'(out0), 0);
    chk("rst_mid_busy", int'(busy0), 0);
    chk("rst_mid_pend", int'(pend0), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clr_tally();
    cyc(1'b1, 1'b0, 1'b0);
    idle(11);
    chk("post_rst_high_cycles", hi0, 5);
    chk("post_rst_rises", rise0, 1);

`ifdef PULSE_STRETCH_RETRIG_EN
    // Strobes every 3 cycles x4 (edges 0,3,6,9): high through edge 13.
    clr_tally();
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      idle(2);
    end
    idle(8);
    chk("retrig_high_cycles", hi0, 14);
    chk("retrig_rises", rise0, 1);
    chk("retrig_pend_max", maxp0, 0);
`endif

    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Safety net so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
